seq_calculator: RTL and testbench
=================================

# seq_calculator

Parametrised, multi-cycle successor to the combinational 8-bit calculator. Accepts operand pairs A/B and a 2-bit opcode over a valid/ready handshake, computes ADD/SUB in one cycle and MUL/DIV iteratively (one bit per cycle), and holds a registered result until the consumer takes it. It sits between the operand source and the result sink of the arithmetic path.

## Interface

Parameters:
- WIDTH, 8, operand width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- in_valid  input  1  A/B/opcode are valid.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- result  output  2*WIDTH  registered result.
- error_flag  output  1  DIV with B == 0; qualified by out_valid.
- out_valid  output  1  result/error_flag are valid.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in MUL_RUN or DIV_RUN.

## Operation

- Accept: on a clk edge where in_valid && in_ready, A, B and opcode are captured. Inputs are ignored while in_ready is low.
- States:
  - IDLE -> DONE for ADD, SUB, or DIV with B == 0.
  - IDLE -> MUL_RUN for MUL.
  - IDLE -> DIV_RUN for DIV with B != 0.
  - MUL_RUN / DIV_RUN -> DONE after WIDTH iterations (internal down-counter).
  - DONE -> IDLE on out_ready.
- ADD: result = zero-extended A + B; the carry lands in bit WIDTH.
- SUB: result = A - B computed modulo 2^(2*WIDTH); A < B wraps, e.g. 5 - 10 = 0xFFFB for WIDTH = 8.
- MUL: unsigned shift-add, one partial product per cycle; full 2*WIDTH product.
- DIV: unsigned restoring division, one quotient bit per cycle. Quotient goes in result[WIDTH-1:0]; see Configuration for the upper half.
- Divide by zero: no iteration; result = 0, error_flag = 1.
- error_flag is 0 for every other operation.
- result, error_flag and out_valid hold stable in DONE until out_ready is sampled high.
- Reset mid-operation aborts the operation with no partial result emitted; the block returns to IDLE.

## Timing

- Reset values: in_ready = 1, out_valid = 0, busy = 0, result = 0, error_flag = 0; state = IDLE; counter = 0.
- ADD, SUB and divide-by-zero: accepted at edge N, out_valid high after edge N+1 (1-cycle latency).
- MUL and DIV: accepted at edge N, busy high after N+1, out_valid high after edge N+WIDTH+1.
- Result handoff occurs on the edge where out_valid && out_ready. in_ready rises after that edge.
- Throughput: 1 op per 2 cycles for ADD/SUB (no accept in the DONE cycle); 1 per WIDTH+2 for MUL/DIV.
- out_ready held high has no effect outside DONE.

## Configuration

- CALC_REMAINDER_EN defined: DIV result[2*WIDTH-1:WIDTH] = remainder.
- CALC_REMAINDER_EN undefined: DIV upper half = 0 and the remainder register is not kept past the final iteration.
- Latency, handshake and all other opcodes are identical either way.

## Structure

- Shared package calc_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - state encoding IDLE, MUL_RUN, DIV_RUN, DONE;
  - WIDTH range limits.
- One sub-module is natural: calc_iter_unit, the shared shift/accumulate datapath.
  - Per iteration it performs either an add-and-shift (MUL) or a subtract/restore-and-shift (DIV), selected by a mode bit.
  - It is driven by the top-level FSM and counter.
- Top level holds the FSM, handshake, ADD/SUB logic and output registers.

## Test plan

All scenarios use WIDTH = 8.
- ADD 200 + 100 -> result 0x012C, error_flag 0; out_valid exactly one cycle after accept.
- SUB 5 - 10 -> result 0xFFFB; SUB 10 - 5 -> 0x0005.
- MUL 255 * 255 -> result 0xFE01; busy for 8 cycles; out_valid 9 cycles after accept. Also MUL 4 * 3 -> 0x000C.
- DIV 200 / 7 -> result 0x041C with CALC_REMAINDER_EN, 0x001C without. DIV 8 / 2 -> 0x0004.
- DIV 8 / 0 -> result 0, error_flag 1, 1-cycle latency.
- Backpressure and reset:
  - Hold out_ready low 5 cycles: result stable, in_ready low, a new in_valid is ignored.
  - Assert rst 3 cycles into a MUL: all outputs return to reset values, and a following ADD completes correctly.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for seq_calculator.
//   - opcode encodings (OP_ADD/OP_SUB/OP_MUL/OP_DIV)
//   - FSM state encoding (IDLE/MUL_RUN/DIV_RUN/DONE)
//   - legal WIDTH range and iteration-counter width
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01,
    DIV_RUN = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Wide enough to hold WIDTH_MAX iterations.
  localparam int CNT_W = $clog2(WIDTH_MAX + 1);

endpackage

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: shared shift/accumulate datapath for iterative MUL and DIV.
// One iteration per step; mode selected by div_mode.
//   MUL: {hi,lo} starts as {0, A}; each step adds B to hi when lo[0] is set,
//        then shifts {carry,hi,lo} right. After WIDTH steps {hi,lo} = A*B.
//   DIV: {hi,lo} starts as {0, A}; each step shifts {hi,lo} left, trial-
//        subtracts B from hi and restores on borrow; the quotient bit enters
//        lo[0]. After WIDTH steps hi = remainder, lo = quotient.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            capture operands (a -> lo, b -> divisor/multiplicand)
//   step            perform one iteration
//   div_mode        1 = restoring-divide step, 0 = shift-add multiply step
//   a, b            operands
//   hi_nxt, lo_nxt  value {hi,lo} takes on this step (lets the caller latch
//                   the final answer on the last iteration edge)
module calc_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] hi, lo, opd;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opd};
    hi_nxt  = sum[WIDTH:1];
    lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    if (div_mode) begin
      // Partial remainder stays below 2*divisor, so a clear top bit of diff
      // means the trial subtraction fits.
      if (diff[WIDTH]) begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      opd <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a;
      opd <= b;
    end else if (step) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned calculator with valid/ready handshake.
// ADD/SUB and divide-by-zero finish in one cycle; MUL/DIV iterate WIDTH
// cycles through calc_iter_unit. Result is registered and held until taken.
// Optional feature macro: CALC_REMAINDER_EN
//   defined   -> DIV places the remainder in result[2*WIDTH-1:WIDTH]
//   undefined -> DIV upper half is zero
// Ports:
//   clk, rst           clock, async active-high reset
//   A, B, opcode       operands and op (00 ADD, 01 SUB, 10 MUL, 11 DIV)
//   in_valid/in_ready  input handshake (ready only in IDLE)
//   result, error_flag registered outputs, qualified by out_valid
//   out_valid/out_ready output handshake
//   busy               high while iterating
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         opcode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               error_flag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, div_zero, last, iter_load;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL_RUN) || (state == DIV_RUN);
  assign accept    = in_valid && in_ready;
  assign div_zero  = (B == '0);
  assign last      = (cnt == CNT_W'(1));
  assign iter_load = accept && ((opcode == OP_MUL) || (opcode == OP_DIV && !div_zero));

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        case (opcode)
          OP_MUL:  state_nxt = MUL_RUN;
          OP_DIV:  state_nxt = div_zero ? DONE : DIV_RUN;
          default: state_nxt = DONE;
        endcase
      end
      MUL_RUN, DIV_RUN: if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      result     <= '0;
      error_flag <= 1'b0;
    end else if (accept) begin
      error_flag <= 1'b0;
      case (opcode)
        OP_ADD: result <= (2*WIDTH)'(A) + (2*WIDTH)'(B);
        OP_SUB: result <= (2*WIDTH)'(A) - (2*WIDTH)'(B);
        OP_MUL: cnt    <= CNT_W'(WIDTH);
        default: begin
          if (div_zero) begin
            result     <= '0;
            error_flag <= 1'b1;
          end else begin
            cnt <= CNT_W'(WIDTH);
          end
        end
      endcase
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      // Latch the answer from the final step's next-value, saving a cycle.
      if (last) begin
        if (state == MUL_RUN) begin
          result <= {hi_nxt, lo_nxt};
        end else begin
`ifdef CALC_REMAINDER_EN
          result <= {hi_nxt, lo_nxt};
`else
          result <= {{WIDTH{1'b0}}, lo_nxt};
`endif
        end
      end
    end
  end

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (iter_load),
    .step     (busy),
    .div_mode (state == DIV_RUN),
    .a        (A),
    .b        (B),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (WIDTH = 8): directed cases,
// backpressure, mid-operation reset, then random ops against an arithmetic
// reference model.
module tb_seq_calculator;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   A = '0, B = '0;
  logic [1:0]     opcode = 2'b00;
  logic           in_valid = 1'b0, out_ready = 1'b0;
  logic           in_ready, error_flag, out_valid, busy;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_calculator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .opcode     (opcode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .error_flag (error_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {error_flag, result}, from plain arithmetic.
  function automatic logic [2*W:0] model(input int unsigned a, input int unsigned b,
                                         input logic [1:0] op);
    logic [63:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      2'd0: r = 64'(a) + 64'(b);
      2'd1: r = 64'(a) - 64'(b);
      2'd2: r = 64'(a) * 64'(b);
      default: begin
        if (b == 0) begin
          r = 64'd0;
          e = 1'b1;
        end else begin
          r = 64'(a / b);
`ifdef CALC_REMAINDER_EN
          r = r | (64'(a % b) << W);
`endif
        end
      end
    endcase
    r = r & ((64'd1 << (2*W)) - 64'd1);
    return {e, r[2*W-1:0]};
  endfunction

  task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                        input logic [1:0] op, input int hold);
    logic [2*W:0] exp;
    int exp_lat, lat, busy_n;
    exp     = model(a, b, op);
    exp_lat = (op == 2'd2 || (op == 2'd3 && b != 0)) ? W + 1 : 1;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    A = W'(a); B = W'(b); opcode = op; in_valid = 1'b1;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (busy) busy_n++;
    end while (!out_valid && lat < 100);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    chk({tag, ".result"}, 64'(result), 64'(exp[2*W-1:0]));
    chk({tag, ".error_flag"}, 64'(error_flag), 64'(exp[2*W]));
    for (int k = 0; k < hold; k++) begin
      A = ~W'(a); B = W'($urandom); opcode = 2'($urandom); in_valid = 1'b1;
      @(negedge clk);
      chk({tag, ".hold_result"}, 64'(result), 64'(exp[2*W-1:0]));
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.error_flag", 64'(error_flag), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("add_200_100", 200, 100, 2'd0, 0);
    run_op("sub_5_10",    5,   10,  2'd1, 0);
    run_op("sub_10_5",    10,  5,   2'd1, 0);
    run_op("mul_255_255", 255, 255, 2'd2, 0);
    run_op("mul_4_3",     4,   3,   2'd2, 0);
    run_op("div_200_7",   200, 7,   2'd3, 0);
    run_op("div_8_2",     8,   2,   2'd3, 0);
    run_op("div_8_0",     8,   0,   2'd3, 0);
    run_op("div_255_1",   255, 1,   2'd3, 0);
    run_op("div_3_200",   3,   200, 2'd3, 0);
    run_op("add_255_255", 255, 255, 2'd0, 0);

    // Backpressure: out_ready low for 5 cycles with new requests offered
    run_op("bp_mul_77_91", 77, 91, 2'd2, 5);
    run_op("bp_sub_1_2",   1,  2,  2'd1, 5);

    // Reset three cycles into a MUL
    @(negedge clk);
    A = 8'd13; B = 8'd11; opcode = 2'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid.in_ready", 64'(in_ready), 64'd1);
    chk("mid.out_valid", 64'(out_valid), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.result", 64'(result), 64'd0);
    chk("mid.error_flag", 64'(error_flag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_add", 17, 25, 2'd0, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      int unsigned ra, rb;
      logic [1:0]  rop;
      ra  = $urandom_range(255);
      rb  = ($urandom_range(7) == 0) ? 0 : $urandom_range(255);
      rop = 2'($urandom);
      run_op($sformatf("rnd%0d_op%0d_%0d_%0d", i, rop, ra, rb), ra, rb, rop,
             int'($urandom_range(2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
